// File: rtl/hpu_pkg.sv
// Shared encodings and default widths for the HPU job sequencer.
package hpu_pkg;

    localparam int ITEM_W = 16;
    localparam int ADDR_W = 20;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } hpu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ABORT   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } hpu_err_t;

endpackage

// File: rtl/hpu_seq_ctrl_if.sv
// Control, config, stream-observe and status signals of the HPU job sequencer.
// master = register file / datapath side, slave = sequencer.
interface hpu_seq_ctrl_if #(
    parameter int ITEM_W = hpu_pkg::ITEM_W,
    parameter int ADDR_W = hpu_pkg::ADDR_W,
    parameter int CNT_W  = hpu_pkg::CNT_W
);
    logic              start;
    logic              abort;
    logic [ITEM_W-1:0] cfg_item_num;
    logic              cfg_skip_init;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [ADDR_W-1:0] cfg_addr_j;
    logic [CNT_W-1:0]  cfg_timeout;
    logic              get_fin;
    logic              dst_valid;
    logic              dst_ready;
    logic              dst_last;
    logic              matw;
    logic [ITEM_W-1:0] mat_a;
    logic              run;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_j;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic              irq;
    logic [2:0]        state_o;
    logic [CNT_W-1:0]  cyc_cnt;

    modport master (
        output start, abort, cfg_item_num, cfg_skip_init, cfg_addr_i, cfg_addr_j, cfg_timeout,
               get_fin, dst_valid, dst_ready, dst_last,
        input  matw, mat_a, run, addr_i, addr_j, busy, done, err, irq, state_o, cyc_cnt
    );

    modport slave (
        input  start, abort, cfg_item_num, cfg_skip_init, cfg_addr_i, cfg_addr_j, cfg_timeout,
               get_fin, dst_valid, dst_ready, dst_last,
        output matw, mat_a, run, addr_i, addr_j, busy, done, err, irq, state_o, cyc_cnt
    );

endinterface

// File: rtl/hpu_watchdog.sv
// Cycle watchdog: counts while enabled, expired pulses in the cycle the count reaches limit.
// Latency: combinational expired from registered count; a zero limit disables it.
// Backpressure: none, purely observes the enable.
module hpu_watchdog #(
    parameter int CNT_W = hpu_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // cnt_q counts completed enabled cycles, so this fires in the limit-th enabled cycle
    assign expired = en && (limit != '0) && (cnt_q == limit - CNT_W'(1));

endmodule

// File: rtl/hpu_seq_ctrl.sv
// Sequencer for one HPU job: item-memory generation, settle gap, run until finish and last beat.
// Latency: all outputs registered; one state transition per clock.
// Backpressure: completion waits for a TLAST beat actually accepted (valid & ready).
module hpu_seq_ctrl
    import hpu_pkg::*;
#(
    parameter int ITEM_W = hpu_pkg::ITEM_W,
    parameter int ADDR_W = hpu_pkg::ADDR_W,
    parameter int CNT_W  = hpu_pkg::CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    hpu_seq_ctrl_if.slave bus
);

    hpu_state_t        state_q;
    hpu_err_t          err_q;
    logic [ITEM_W-1:0] item_num_q;
    logic [ITEM_W-1:0] mat_a_q;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [ADDR_W-1:0] addr_i_q;
    logic [ADDR_W-1:0] addr_j_q;
    logic              matw_q;
    logic              run_q;
    logic              done_q;
    logic              irq_q;
    logic              last_beat;
    logic              wd_en;
    logic              wd_clr;
    logic              wd_expired;

    assign last_beat = bus.dst_valid & bus.dst_ready & bus.dst_last;
    assign wd_en     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign wd_clr    = (state_q == ST_SETTLE);

    hpu_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .limit   (timeout_q),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            item_num_q <= '0;
            mat_a_q    <= '0;
            timeout_q  <= '0;
            cyc_q      <= '0;
            addr_i_q   <= '0;
            addr_j_q   <= '0;
            matw_q     <= 1'b0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (state_q != ST_IDLE && cyc_q != '1) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end

            if (state_q == ST_IDLE) begin
                // abort in IDLE is ignored, but it still suppresses a coincident start
                if (bus.start && !bus.abort) begin
                    item_num_q <= bus.cfg_item_num;
                    timeout_q  <= bus.cfg_timeout;
                    addr_i_q   <= bus.cfg_addr_i;
                    addr_j_q   <= bus.cfg_addr_j;
                    done_q     <= 1'b0;
                    err_q      <= ERR_NONE;
                    cyc_q      <= '0;
                    mat_a_q    <= '0;
                    if (bus.cfg_skip_init) begin
                        state_q <= ST_SETTLE;
                    end else begin
                        state_q <= ST_INIT;
                        matw_q  <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                state_q <= ST_IDLE;
                matw_q  <= 1'b0;
                mat_a_q <= '0;
                run_q   <= 1'b0;
                err_q   <= ERR_ABORT;
                irq_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        // compare before increment so an all-ones item count never wraps
                        if (mat_a_q == item_num_q) begin
                            state_q <= ST_SETTLE;
                            matw_q  <= 1'b0;
                            mat_a_q <= '0;
                        end else begin
                            mat_a_q <= mat_a_q + ITEM_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                    ST_RUN, ST_DRAIN: begin
                        if (wd_expired) begin
                            state_q <= ST_IDLE;
                            run_q   <= 1'b0;
                            err_q   <= ERR_TIMEOUT;
                            irq_q   <= 1'b1;
                        end else if (last_beat && (state_q == ST_DRAIN || bus.get_fin)) begin
                            state_q <= ST_DONE;
                            run_q   <= 1'b0;
                            done_q  <= 1'b1;
                            irq_q   <= 1'b1;
                        end else if (bus.get_fin) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.matw    = matw_q;
    assign bus.mat_a   = mat_a_q;
    assign bus.run     = run_q;
    assign bus.addr_i  = addr_i_q;
    assign bus.addr_j  = addr_j_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.irq     = irq_q;
    assign bus.state_o = state_q;
    assign bus.cyc_cnt = cyc_q;

endmodule
